// File: rtl/tipi_rpi_link_if.sv
// Command/response handshake between a requester and the TIPI serial link master.
interface tipi_rpi_link_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_sel;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;

    modport master (
        output cmd_valid, cmd_sel, cmd_wdata,
        input  cmd_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  cmd_valid, cmd_sel, cmd_wdata,
        output cmd_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/tipi_rpi_link.sv
// Serial link master toward the TIPI register block: one byte per command over r_clk/r_le/r_dout/r_din.
// Defining TIPI_LINK_POLL_EN adds background TC polling (poll_en, tc_value, tc_changed).
module tipi_rpi_link #(
    parameter int HALF_PERIOD = 4
) (
    input  logic           clk,
    input  logic           reset_n,
    tipi_rpi_link_if.slave bus,
`ifdef TIPI_LINK_POLL_EN
    input  logic           poll_en,
    output logic [7:0]     tc_value,
    output logic           tc_changed,
`endif
    output logic           r_clk,
    output logic           r_le,
    output logic           r_rt,
    output logic           r_cd,
    output logic           r_dout,
    input  logic           r_din
);
    typedef enum logic [2:0] {IDLE, SETUP, PULSE_HI, PULSE_LO, DONE} state_t;

    localparam logic [7:0] LAST_CNT   = 8'(HALF_PERIOD - 1);
    localparam logic [3:0] LAST_PULSE = 4'd8;

    state_t     state, state_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic [3:0] pulse, pulse_nxt;
    logic       ready_q, rsp_valid_q, intl, read_q;
    logic [7:0] rsp_rdata_q, wdata_q, shreg, shreg_nxt;
    logic       din_p0, din_p1;
    logic       start, start_int, go, phase_end, sample;
    logic [1:0] sel_go;
    logic [7:0] wdata_go;

    // Reads load on pulse 0; writes shift eight data pulses and latch on pulse 8.
    function automatic logic pulse_le(input logic rd, input logic [3:0] k);
        return rd ? (k == 4'd0) : (k == 4'd8);
    endfunction

    function automatic logic pulse_dout(input logic rd, input logic [7:0] wd, input logic [3:0] k);
        if (rd || k > 4'd7) return 1'b0;
        return wd[3'd7 - k[2:0]];
    endfunction

    assign phase_end = (cnt == LAST_CNT);
    assign shreg_nxt = {shreg[6:0], din_p1};
    assign go        = start | start_int;
    assign sel_go    = start ? bus.cmd_sel : 2'b10;
    assign wdata_go  = start ? bus.cmd_wdata : 8'h00;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pulse_nxt = pulse;
        start     = 1'b0;
        start_int = 1'b0;
        sample    = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt   = '0;
                pulse_nxt = '0;
                if (ready_q && bus.cmd_valid) begin
                    start     = 1'b1;
                    state_nxt = SETUP;
                end
`ifdef TIPI_LINK_POLL_EN
                else if (ready_q && poll_en) begin
                    start_int = 1'b1;
                    state_nxt = SETUP;
                end
`endif
            end
            SETUP, PULSE_HI: begin
                cnt_nxt = cnt + 8'd1;
                if (phase_end) begin
                    cnt_nxt   = '0;
                    state_nxt = (state == SETUP) ? PULSE_HI : PULSE_LO;
                end
            end
            PULSE_LO: begin
                cnt_nxt = cnt + 8'd1;
                if (phase_end) begin
                    cnt_nxt = '0;
                    sample  = read_q && (pulse != 4'd0);
                    if (pulse == LAST_PULSE) begin
                        state_nxt = DONE;
                    end else begin
                        pulse_nxt = pulse + 4'd1;
                        state_nxt = PULSE_HI;
                    end
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
            pulse <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            pulse <= pulse_nxt;
        end
    end

    // r_din synchronizer: din_p1 is the first usable copy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            din_p0 <= 1'b0;
            din_p1 <= 1'b0;
        end else begin
            din_p0 <= r_din;
            din_p1 <= din_p0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            intl        <= 1'b0;
            read_q      <= 1'b0;
            wdata_q     <= '0;
            shreg       <= '0;
            r_clk       <= 1'b0;
            r_le        <= 1'b0;
            r_dout      <= 1'b0;
            r_rt        <= 1'b0;
            r_cd        <= 1'b0;
`ifdef TIPI_LINK_POLL_EN
            tc_value    <= '0;
            tc_changed  <= 1'b0;
`endif
        end else begin
            ready_q <= (state_nxt == IDLE);
            r_clk   <= (state_nxt == PULSE_HI);
            // r_le/r_dout move only as r_clk falls, a full low phase ahead of the next rise.
            if (go) begin
                intl    <= start_int;
                read_q  <= sel_go[1];
                wdata_q <= wdata_go;
                r_rt    <= sel_go[1];
                r_cd    <= sel_go[0];
                r_le    <= pulse_le(sel_go[1], 4'd0);
                r_dout  <= pulse_dout(sel_go[1], wdata_go, 4'd0);
            end else if (state == PULSE_HI && phase_end) begin
                r_le    <= pulse_le(read_q, pulse + 4'd1);
                r_dout  <= pulse_dout(read_q, wdata_q, pulse + 4'd1);
            end
            if (sample) shreg <= shreg_nxt;
            rsp_valid_q <= (state_nxt == DONE) && !intl;
            if (state_nxt == DONE && !intl) rsp_rdata_q <= read_q ? shreg_nxt : 8'h00;
`ifdef TIPI_LINK_POLL_EN
            tc_changed <= 1'b0;
            if (state_nxt == DONE && read_q && !r_cd && shreg_nxt != tc_value) begin
                tc_value   <= shreg_nxt;
                tc_changed <= 1'b1;
            end
`endif
        end
    end

    assign bus.cmd_ready = ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
endmodule

// File: tb/tb_tipi_rpi_link.sv
// Bench for tipi_rpi_link: register-block models on the serial side, a transaction-level model for DUT A.
`timescale 1ns/1ps
module tb_tipi_rpi_link;
    localparam int HPA    = 4;
    localparam int HPB    = 3;
    localparam int DONE_A = 19*HPA + 1;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    tipi_rpi_link_if bus_a();
    tipi_rpi_link_if bus_b();

    logic r_clk_a, r_le_a, r_rt_a, r_cd_a, r_dout_a;
    logic r_clk_b, r_le_b, r_rt_b, r_cd_b, r_dout_b;
    logic r_din_a = 1'b0;
    logic r_din_b = 1'b0;
`ifdef TIPI_LINK_POLL_EN
    logic       poll_en_a = 1'b0;
    logic       poll_en_b = 1'b0;
    logic [7:0] tc_value_a, tc_value_b;
    logic       tc_changed_a, tc_changed_b;
    bit         mon_en = 1'b0;
    int         n_chg = 0;
    int         n_rsp = 0;
`endif

    tipi_rpi_link #(.HALF_PERIOD(HPA)) u_dut_a (
        .clk(clk), .reset_n(reset_n), .bus(bus_a.slave),
`ifdef TIPI_LINK_POLL_EN
        .poll_en(poll_en_a), .tc_value(tc_value_a), .tc_changed(tc_changed_a),
`endif
        .r_clk(r_clk_a), .r_le(r_le_a), .r_rt(r_rt_a), .r_cd(r_cd_a),
        .r_dout(r_dout_a), .r_din(r_din_a)
    );

    tipi_rpi_link #(.HALF_PERIOD(HPB)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .bus(bus_b.slave),
`ifdef TIPI_LINK_POLL_EN
        .poll_en(poll_en_b), .tc_value(tc_value_b), .tc_changed(tc_changed_b),
`endif
        .r_clk(r_clk_b), .r_le(r_le_b), .r_rt(r_rt_b), .r_cd(r_cd_b),
        .r_dout(r_dout_b), .r_din(r_din_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // TIPI register block models: load/shift on r_clk rise; r_din shows the next bit after each non-load rise.
    logic [7:0] reg_tc_a, reg_td_a, reg_rc_a, reg_rd_a, wsh_a, rsh_a;
    logic [7:0] reg_tc_b, reg_td_b, reg_rc_b, reg_rd_b, wsh_b, rsh_b;

    always @(posedge r_clk_a) begin
        if (r_rt_a) begin
            if (r_le_a) rsh_a <= r_cd_a ? reg_td_a : reg_tc_a;
            else begin r_din_a <= rsh_a[7]; rsh_a <= {rsh_a[6:0], 1'b0}; end
        end else begin
            if (r_le_a) begin if (r_cd_a) reg_rd_a <= wsh_a; else reg_rc_a <= wsh_a; end
            else wsh_a <= {wsh_a[6:0], r_dout_a};
        end
    end

    always @(posedge r_clk_b) begin
        if (r_rt_b) begin
            if (r_le_b) rsh_b <= r_cd_b ? reg_td_b : reg_tc_b;
            else begin r_din_b <= rsh_b[7]; rsh_b <= {rsh_b[6:0], 1'b0}; end
        end else begin
            if (r_le_b) begin if (r_cd_b) reg_rd_b <= wsh_b; else reg_rc_b <= wsh_b; end
            else wsh_b <= {wsh_b[6:0], r_dout_b};
        end
    end

    // Transaction model for DUT A: m_t counts cycles since acceptance (-1 when idle).
    int         m_t     = -1;
    bit         m_ready = 1'b0;
    logic [1:0] m_sel   = 2'b00;
    logic [7:0] m_wd    = 8'h00;
    logic [7:0] m_exp   = 8'h00;
    logic [7:0] m_rdata = 8'h00;
    bit         chk_en  = 1'b1;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_t = -1; m_ready = 1'b0; m_sel = 2'b00; m_rdata = 8'h00;
        end else if (m_t == DONE_A) begin
            m_t = -1; m_ready = 1'b1;
        end else if (m_t >= 0) begin
            m_t++;
            if (m_t == DONE_A) m_rdata = m_sel[1] ? m_exp : 8'h00;
        end else if (!m_ready) begin
            m_ready = 1'b1;
        end else if (bus_a.cmd_valid) begin
            m_t = 1; m_ready = 1'b0;
            m_sel = bus_a.cmd_sel; m_wd = bus_a.cmd_wdata;
            m_exp = bus_a.cmd_sel[0] ? reg_td_a : reg_tc_a;
        end
    end

    int cu, cp;
    bit chi;
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cmd_ready", 32'(bus_a.cmd_ready), 32'(m_ready));
            chk("rsp_valid", 32'(bus_a.rsp_valid), 32'(m_t == DONE_A));
            chk("rsp_rdata", 32'(bus_a.rsp_rdata), 32'(m_rdata));
            chk("r_rt_cd", 32'({r_rt_a, r_cd_a}), 32'(m_sel));
            chi = 1'b0; cp = 0;
            if (m_t > HPA && m_t < DONE_A) begin
                cu  = m_t - HPA - 1;
                cp  = cu / (2*HPA);
                chi = (cu % (2*HPA)) < HPA;
            end
            chk("r_clk", 32'(r_clk_a), 32'(chi));
            if (chi) begin
                chk("r_le", 32'(r_le_a), 32'(m_sel[1] ? (cp == 0) : (cp == 8)));
                chk("r_dout", 32'(r_dout_a), 32'((!m_sel[1] && cp < 8) ? m_wd[7-cp] : 1'b0));
            end
        end
`ifdef TIPI_LINK_POLL_EN
        if (mon_en) begin
            if (tc_changed_a) n_chg++;
            if (bus_a.rsp_valid) n_rsp++;
        end
`endif
    end

    task automatic run_cmd(input bit on_b, input logic [1:0] sel, input logic [7:0] wd,
                           output int lat, output logic [7:0] rd);
        bit got;
        lat = -1; rd = 8'h00; got = 1'b0;
        @(negedge clk);
        if (on_b) begin bus_b.cmd_sel = sel; bus_b.cmd_wdata = wd; bus_b.cmd_valid = 1'b1; end
        else      begin bus_a.cmd_sel = sel; bus_a.cmd_wdata = wd; bus_a.cmd_valid = 1'b1; end
        for (int i = 0; i < 100; i++) begin
            if (on_b ? bus_b.cmd_ready : bus_a.cmd_ready) begin got = 1'b1; break; end
            @(negedge clk);
        end
        chk("accept", 32'(got), 32'd1);
        @(negedge clk);
        bus_a.cmd_valid = 1'b0;
        bus_b.cmd_valid = 1'b0;
        if (got) begin
            for (int k = 1; k < 400; k++) begin
                if (on_b ? bus_b.rsp_valid : bus_a.rsp_valid) begin
                    lat = k;
                    rd  = on_b ? bus_b.rsp_rdata : bus_a.rsp_rdata;
                    break;
                end
                @(negedge clk);
            end
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, g0, g1, rises;
        logic [7:0] rd;
        bit prev;
        bus_a.cmd_valid = 1'b0; bus_a.cmd_sel = 2'b00; bus_a.cmd_wdata = 8'h00;
        bus_b.cmd_valid = 1'b0; bus_b.cmd_sel = 2'b00; bus_b.cmd_wdata = 8'h00;
        reg_tc_a = 8'h81; reg_td_a = 8'h3C;
        reg_tc_b = 8'h00; reg_td_b = 8'hFF;

        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(bus_a.cmd_ready), 32'd0);
        chk("rst_rclk", 32'(r_clk_a), 32'd0);
        chk("rst_rdata", 32'(bus_a.rsp_rdata), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", 32'(bus_a.cmd_ready), 32'd1);

        run_cmd(1'b0, 2'b01, 8'hA5, lat, rd);
        chk("wr_latency", 32'(lat), 32'd77);
        chk("wr_rdata", 32'(rd), 32'd0);
        chk("wr_rd_reg", 32'(reg_rd_a), 32'hA5);
        run_cmd(1'b0, 2'b00, 8'h5C, lat, rd);
        chk("wr_rc_reg", 32'(reg_rc_a), 32'h5C);

        run_cmd(1'b0, 2'b11, 8'h00, lat, rd);
        chk("rd_td", 32'(rd), 32'h3C);
        chk("rd_latency", 32'(lat), 32'd77);
        run_cmd(1'b0, 2'b10, 8'h00, lat, rd);
        chk("rd_tc", 32'(rd), 32'h81);

        // cmd_valid held high through two transactions
        @(negedge clk);
        bus_a.cmd_sel = 2'b11; bus_a.cmd_valid = 1'b1;
        g0 = -1; g1 = -1;
        for (int i = 0; i < 400 && g1 < 0; i++) begin
            @(negedge clk);
            if (bus_a.rsp_valid) begin if (g0 < 0) g0 = i; else g1 = i; end
        end
        bus_a.cmd_valid = 1'b0;
        chk("b2b_gap", 32'(g1 - g0), 32'd78);

        // reset during read pulse 5
        reg_td_a = 8'h5A;
        @(negedge clk);
        bus_a.cmd_sel = 2'b11; bus_a.cmd_valid = 1'b1;
        @(negedge clk);
        bus_a.cmd_valid = 1'b0;
        rises = 0; prev = 1'b0;
        for (int i = 0; i < 300 && rises < 5; i++) begin
            @(negedge clk);
            if (r_clk_a && !prev) rises++;
            prev = r_clk_a;
        end
        chk("pulse5_reached", 32'(rises), 32'd5);
        #1 reset_n = 1'b0;
        #1;
        chk("abort_rclk", 32'(r_clk_a), 32'd0);
        chk("abort_rsp", 32'(bus_a.rsp_valid), 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("ready_after_abort", 32'(bus_a.cmd_ready), 32'd1);
        run_cmd(1'b0, 2'b11, 8'h00, lat, rd);
        chk("rd_after_abort", 32'(rd), 32'h5A);

        // HALF_PERIOD=3 instance
        run_cmd(1'b1, 2'b11, 8'h00, lat, rd);
        chk("b_rd_ff", 32'(rd), 32'hFF);
        chk("b_latency", 32'(lat), 32'd58);
        reg_td_b = 8'h00;
        run_cmd(1'b1, 2'b11, 8'h00, lat, rd);
        chk("b_rd_00", 32'(rd), 32'h00);
        reg_td_b = 8'hC3;
        run_cmd(1'b1, 2'b11, 8'h00, lat, rd);
        chk("b_rd_c3", 32'(rd), 32'hC3);

`ifdef TIPI_LINK_POLL_EN
        chk_en = 1'b0;
        reg_tc_a = 8'h00;
        mon_en = 1'b1;
        poll_en_a = 1'b1;
        repeat (3*(DONE_A+1)) @(negedge clk);
        chk("poll_no_change", 32'(n_chg), 32'd0);
        reg_tc_a = 8'h42;
        repeat (4*(DONE_A+1)) @(negedge clk);
        chk("poll_one_pulse", 32'(n_chg), 32'd1);
        chk("poll_tc_value", 32'(tc_value_a), 32'h42);
        chk("poll_no_rsp", 32'(n_rsp), 32'd0);
        poll_en_a = 1'b0;
        mon_en = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
